// File: rtl/e_calc_stream_if.sv
// Control and limb-stream bundle for e_calc_stream.
// The master side is the calculator, which produces the result stream.
interface e_calc_stream_if #(
  parameter int LIMB_W = 16,
  parameter int K_W    = 16
) ();
  logic              start;
  logic [K_W-1:0]    k_in;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [LIMB_W-1:0] out_data;
  logic              out_last;
  logic              out_err;

  modport master (
    input  start, k_in, out_ready,
    output busy, out_valid, out_data, out_last, out_err
  );

  modport slave (
    output start, k_in, out_ready,
    input  busy, out_valid, out_data, out_last, out_err
  );
endinterface

// File: rtl/e_calc_stream.sv
// Computes (1 + 2^-k)^(2^k) by k in-place squarings on one limb-serial MAC,
// then streams the fixed-point result out LSB limb first.
module e_calc_stream #(
  parameter int WORDS  = 32,
  parameter int LIMB_W = 16,
  parameter int K_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  e_calc_stream_if.master bus
);
  localparam int F  = LIMB_W * (WORDS - 1);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(2 * WORDS - 1);
  localparam int AW = 2 * LIMB_W + $clog2(WORDS) + 1;
  localparam int XW = WORDS * LIMB_W;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SQUARE, S_OUT} state_t;
  typedef enum logic [1:0] {P_MAC, P_COMMIT, P_FINAL} phase_t;

  state_t            r_state;
  state_t            w_next;
  phase_t            r_phase;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    r_cnt;
  logic [CW-1:0]     r_col;
  logic [IW-1:0]     r_i;
  logic [AW-1:0]     r_acc;
  logic [LIMB_W-1:0] r_x    [WORDS];
  // Only product limbs WORDS-1 .. 2*WORDS-2 survive the rescale, so only those are kept.
  logic [LIMB_W-1:0] r_prod [WORDS];
  logic [IW-1:0]     r_idx;
  logic              r_busy;
  logic              r_valid;
  logic              r_last;
  logic              r_err;
  logic [LIMB_W-1:0] r_data;

  logic                w_err;
  logic [K_W-1:0]      w_sh;
  logic [XW-1:0]       w_init;
  logic [IW-1:0]       w_j;
  logic [2*LIMB_W-1:0] w_pp;
  logic [IW-1:0]       w_i_hi;
  logic [CW-1:0]       w_col_nx;
  logic [IW-1:0]       w_i_lo_nx;
  logic [IW-1:0]       w_idx_nx;
  logic                w_hs;

  assign w_err     = (r_k > K_W'(F));
  assign w_sh      = K_W'(F) - r_k;
  // Addition rather than OR so that k = 0 folds both terms into 2.0.
  assign w_init    = ({{(XW-1){1'b0}}, 1'b1} << F) + ({{(XW-1){1'b0}}, 1'b1} << w_sh);
  assign w_j       = IW'(r_col - CW'(r_i));
  assign w_pp      = r_x[r_i] * r_x[w_j];
  assign w_i_hi    = (r_col < CW'(WORDS - 1)) ? IW'(r_col) : IW'(WORDS - 1);
  assign w_col_nx  = r_col + {{(CW-1){1'b0}}, 1'b1};
  assign w_i_lo_nx = (w_col_nx > CW'(WORDS - 1)) ? IW'(w_col_nx - CW'(WORDS - 1)) : {IW{1'b0}};
  assign w_idx_nx  = r_idx + {{(IW-1){1'b0}}, 1'b1};
  assign w_hs      = r_valid & bus.out_ready;

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign bus.out_err   = r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_INIT;
        else           w_next = S_IDLE;
      end
      S_INIT: begin
        if (w_err || (r_k == {K_W{1'b0}})) w_next = S_OUT;
        else                               w_next = S_SQUARE;
      end
      S_SQUARE: begin
        if ((r_phase == P_FINAL) && (r_cnt == K_W'(1))) w_next = S_OUT;
        else                                            w_next = S_SQUARE;
      end
      S_OUT: begin
        if (w_hs && r_last) w_next = S_IDLE;
        else                w_next = S_OUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand setup, product-scanning MAC, and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= P_MAC;
      r_k     <= {K_W{1'b0}};
      r_cnt   <= {K_W{1'b0}};
      r_col   <= {CW{1'b0}};
      r_i     <= {IW{1'b0}};
      r_acc   <= {AW{1'b0}};
      r_idx   <= {IW{1'b0}};
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= {LIMB_W{1'b0}};
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_valid <= (w_next == S_OUT);
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_k <= bus.k_in;
          r_last <= 1'b0;
          r_err  <= 1'b0;
        end
        S_INIT: begin
          r_err   <= w_err;
          r_cnt   <= r_k;
          r_phase <= P_MAC;
          r_col   <= {CW{1'b0}};
          r_i     <= {IW{1'b0}};
          r_acc   <= {AW{1'b0}};
          r_idx   <= {IW{1'b0}};
          r_last  <= 1'b0;
          r_data  <= w_err ? {LIMB_W{1'b0}} : w_init[LIMB_W-1:0];
          for (int n = 0; n < WORDS; n++) begin
            r_x[n] <= w_err ? {LIMB_W{1'b0}} : w_init[n*LIMB_W +: LIMB_W];
          end
        end
        S_SQUARE: begin
          case (r_phase)
            P_MAC: begin
              r_acc <= r_acc + AW'(w_pp);
              if (r_i == w_i_hi) r_phase <= P_COMMIT;
              else               r_i     <= r_i + {{(IW-1){1'b0}}, 1'b1};
            end
            P_COMMIT: begin
              if (r_col >= CW'(WORDS - 1)) begin
                r_prod[IW'(r_col - CW'(WORDS - 1))] <= r_acc[LIMB_W-1:0];
              end
              r_acc <= r_acc >> LIMB_W;
              if (r_col == CW'(2 * WORDS - 2)) begin
                r_phase <= P_FINAL;
              end else begin
                r_col   <= w_col_nx;
                r_i     <= w_i_lo_nx;
                r_phase <= P_MAC;
              end
            end
            P_FINAL: begin
              for (int n = 0; n < WORDS; n++) begin
                r_x[n] <= r_prod[n];
              end
              r_cnt   <= r_cnt - K_W'(1);
              r_col   <= {CW{1'b0}};
              r_i     <= {IW{1'b0}};
              r_acc   <= {AW{1'b0}};
              r_phase <= P_MAC;
              r_data  <= r_prod[0];
              r_last  <= 1'b0;
            end
            default: r_phase <= P_MAC;
          endcase
        end
        S_OUT: begin
          if (w_hs) begin
            if (r_last) begin
              r_last <= 1'b0;
              r_err  <= 1'b0;
            end else begin
              r_idx  <= w_idx_nx;
              r_data <= r_x[w_idx_nx];
              r_last <= (w_idx_nx == IW'(WORDS - 1));
            end
          end
        end
        default: r_phase <= P_MAC;
      endcase
    end
  end
endmodule

// File: tb/tb_e_calc_stream.sv
// Self-checking bench for e_calc_stream (WORDS=4, LIMB_W=16): vector table,
// limb scoreboard, backpressure, ignored start and mid-run reset.
module tb_e_calc_stream;
  localparam int W  = 4;
  localparam int L  = 16;
  localparam int KW = 16;
  localparam int F  = L * (W - 1);
  localparam int S  = W * W + 2 * W;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        err;
  } limb_t;

  typedef struct {
    logic [15:0] k;
    int          lat;
    logic [63:0] x;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic toggle = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  limb_t exp_q[$];
  int    first_cyc;
  logic  seen_valid = 1'b0;
  int    n_hs = 0;
  logic  chk_idle_next = 1'b0;
  logic  p_valid = 1'b0;
  logic  p_ready = 1'b0;
  limb_t p_limb;
  logic [15:0] got [W];

  e_calc_stream_if #(.LIMB_W(L), .K_W(KW)) bus ();

  e_calc_stream #(.WORDS(W), .LIMB_W(L), .K_W(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (toggle) bus.out_ready = ~bus.out_ready;
    else        bus.out_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: square the whole 64-bit value, keep bits [111:48].
  function automatic logic [63:0] model(input int k);
    logic [63:0]  x;
    logic [127:0] p;
    if (k > F) return 64'd0;
    x = (64'd1 << F) + (64'd1 << (F - k));
    for (int n = 0; n < k; n++) begin
      p = {64'd0, x} * {64'd0, x};
      x = p[111:48];
    end
    return x;
  endfunction

  // Stream monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    limb_t e;
    if (rst) begin
      p_valid = 1'b0;
      chk_idle_next = 1'b0;
    end else begin
      if (chk_idle_next) begin
        chk("idle_after_last", {62'd0, bus.busy, bus.out_valid}, 64'd0);
        chk_idle_next = 1'b0;
      end
      if (p_valid && !p_ready && bus.out_valid)
        chk("stall_hold", {46'd0, bus.out_data, bus.out_last, bus.out_err},
            {46'd0, p_limb.data, p_limb.last, p_limb.err});
      if (bus.out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (n_hs < W) got[n_hs] = bus.out_data;
        n_hs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_limb: got %0h with no limb outstanding", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("limb_data", {48'd0, bus.out_data}, {48'd0, e.data});
          chk("limb_flags", {62'd0, bus.out_last, bus.out_err}, {62'd0, e.last, e.err});
        end
        if (bus.out_last) chk_idle_next = 1'b1;
      end
      p_valid   = bus.out_valid;
      p_ready   = bus.out_ready;
      p_limb.data = bus.out_data;
      p_limb.last = bus.out_last;
      p_limb.err  = bus.out_err;
    end
  end

  task automatic run(input logic [15:0] k, input int lat, input logic [63:0] x,
                     input logic err, input logic pulse);
    int   t0;
    logic done;
    for (int n = 0; n < W; n++) begin
      limb_t e;
      e.data = x[n*16 +: 16];
      e.last = (n == W - 1);
      e.err  = err;
      exp_q.push_back(e);
    end
    seen_valid = 1'b0;
    n_hs = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_in  = k;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.k_in  = 16'hFFFF;
    chk("busy_at_T+1", {63'd0, bus.busy}, 64'd1);
    if (lat > 2) chk("no_valid_at_T+1", {63'd0, bus.out_valid}, 64'd0);
    if (pulse) begin
      repeat (10) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.k_in  = 16'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    done = 1'b0;
    for (int c = 0; c < lat + 60; c++) begin
      if (n_hs == W && !bus.busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout k=%0d: handshakes %0d, busy %0b", k, n_hs, bus.busy);
    end
    @(negedge clk); #1;
    if (seen_valid) chk("first_valid_latency", 64'(first_cyc - t0), 64'(lat));
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL first_valid_latency: no out_valid seen, want %0d", lat);
    end
    chk("handshake_count", 64'(n_hs), 64'(W));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  vec_t tbl [6];

  initial begin
    bus.start     = 1'b0;
    bus.k_in      = 16'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {45'd0, bus.busy, bus.out_valid, bus.out_last, bus.out_err, bus.out_data},
        64'd0);
    rst = 1'b0;

    tbl[0] = '{16'd0,  2,          64'h0002_0000_0000_0000, 1'b0};
    tbl[1] = '{16'd1,  2 + S,      64'h0002_4000_0000_0000, 1'b0};
    tbl[2] = '{16'd2,  2 + 2 * S,  64'h0002_7100_0000_0000, 1'b0};
    tbl[3] = '{16'd15, 2 + 15 * S, model(15),               1'b0};
    tbl[4] = '{16'd48, 2 + 48 * S, model(48),               1'b0};
    tbl[5] = '{16'd49, 2,          64'd0,                   1'b1};

    for (int v = 0; v < 6; v++) begin
      run(tbl[v].k, tbl[v].lat, tbl[v].x, tbl[v].err, 1'b0);
      if (tbl[v].k == 16'd15) begin
        chk("k15_int_limb", {48'd0, got[3]}, 64'h0002);
        chk("k15_top_frac", {48'd0, got[2]}, 64'hB7DE);
      end
    end

    // Backpressure plus a start pulse that must be ignored mid-squaring.
    toggle = 1'b1;
    run(16'd2, 2 + 2 * S, 64'h0002_7100_0000_0000, 1'b0, 1'b1);
    toggle = 1'b0;

    // Reset in the middle of SQUARE.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_in  = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_square", {45'd0, bus.busy, bus.out_valid, bus.out_last, bus.out_err, bus.out_data},
        64'd0);
    repeat (4 * S) @(posedge clk);
    #1;
    chk("no_resume_after_rst", {62'd0, bus.busy, bus.out_valid}, 64'd0);

    run(16'd1, 2 + S, 64'h0002_4000_0000_0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/e_calc_stream.md
Name: e_calc_stream

Overview:
Runtime-configurable successor to the fixed-N e calculator. Computes (1 + 2^-k)^(2^k) in multi-limb fixed point by k sequential in-place squarings on a single limb-serial multiply-accumulate unit. The result is streamed out limb by limb over a valid/ready handshake, so WORDS can scale without a wide parallel result bus. It sits between the control sequencer (start/k) and the fixed-to-real conversion stage.

Parameters:
WORDS, 32, number of limbs in the operand and the result; must be ≥ 2.
LIMB_W, 16, bits per limb.
K_W, 16, width of k_in; must hold LIMB_W*(WORDS-1).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  start request; sampled only in IDLE.
k_in  in  K_W  exponent k; N = 2^k; captured with start.
busy  out  1  high from the cycle after start is accepted until the last limb handshake.
out_valid  out  1  output limb valid.
out_ready  in  1  consumer ready.
out_data  out  LIMB_W  output limb, LSB limb first.
out_last  out  1  high with limb WORDS-1.
out_err  out  1  held for the whole stream when k is out of range.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Number format: value = X / 2^F, with F = LIMB_W*(WORDS-1).
  - limb WORDS-1 is the integer part.
  - limbs WORDS-2..0 are the fraction.
- Reset:
  - state IDLE.
  - busy, out_valid, out_last, out_err = 0.
  - out_data = 0.
  - limb storage is not reset.
- States: IDLE, INIT, SQUARE, OUT.
- IDLE:
  - start=1 at cycle T: capture k_in and go to INIT.
  - busy=1 from T+1.
- INIT (1 cycle):
  - X = 2^F + 2^(F-k), i.e. integer limb = 1 with bit F-k set.
  - k=0 gives X = 2.0.
  - If k > F: out_err=1, X = 0, skip to OUT.
  - If k = 0: go directly to OUT.
  - Otherwise go to SQUARE with remaining count = k.
- SQUARE (product scanning):
  - Columns c = 0..2*WORDS-2. Each column takes one cycle per partial product X[i]*X[c-i], followed by one commit cycle.
  - Accumulator width is 2*LIMB_W + clog2(WORDS) + 1.
  - Commit: low LIMB_W bits go to product limb c; the accumulator shifts right by LIMB_W.
  - Final cycle: X = product limbs [2*WORDS-2 .. WORDS-1].
    - Lower fraction limbs are truncated, not rounded.
    - Bits above the integer limb are discarded.
  - Exact latency per squaring: S = WORDS^2 + 2*WORDS cycles.
  - Decrement the count after each squaring. Go to OUT when the count reaches 0.
- First out_valid timing: cycle T+2+k*S for valid k ≥ 1; cycle T+2 for k=0 and for the error case.
- OUT:
  - Limb index starts at 0. out_data = X[idx]; out_valid=1.
  - On out_valid & out_ready: idx++.
  - out_data, out_last and out_err are stable while out_valid=1 and out_ready=0.
  - Handshake with out_last=1: next cycle is IDLE, with busy=0 and out_valid=0.
  - A back-to-back start is accepted in the cycle after that handshake, not during it.
- start while not in IDLE is ignored; k_in is ignored outside the accept cycle.
- rst asserted at any point (mid-SQUARE or mid-OUT): next cycle is IDLE with all outputs at reset values. No partial stream resumes.
- The multiplier is reused for every squaring; it is not duplicated per limb.

Test Plan:
- Setup: WORDS=4, LIMB_W=16, out_ready=1, start with k=0 -> out_valid at T+2; limbs (LSB first) 0000,0000,0000,0002; out_last on the 4th limb; out_err=0.
- k=1 -> first out_valid at T+2+24; limbs 0000,0000,4000,0002 (value 2.25).
- k=2 -> first out_valid at T+2+48; limbs 0000,0000,7100,0002 (value 2.44140625, exact).
- k=15 -> first out_valid at T+2+360.
  - Integer limb 0002; top fraction limb 0xB7DE.
  - Full result bit-exact against a bench reference model using the same truncation.
- k=49 (>F=48) -> out_err=1 on all 4 limbs; all limbs 0000; out_valid at T+2.
- Backpressure and control:
  - k=2 with out_ready toggled 0/1 every cycle: data is held stable while stalled, and exactly 4 handshakes occur.
  - start pulsed during SQUARE is ignored.
  - rst mid-SQUARE: IDLE next cycle, out_valid=0.
  - A subsequent k=1 run still yields 2.25.
